// File: rtl/segscan_decoder.sv
// segscan_decoder: receive-side monitor for a multiplexed 4-digit 7-segment
// scan bus. Segments lit while a digit strobe is held are ORed together.
// When the strobe ends, the pattern is decoded back to a BCD value.
//
// state | meaning
// IDLE  | no digit strobe active
// ACCUM | single strobe active, accumulating segments for slot r_k
// BAD   | multi-hot strobe seen, waiting for zero or one-hot
module segscan_decoder #(
  parameter int MIN_HOLD  = 4,
  parameter int HOLD_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digits,
  input  logic [7:0]  segments,
  output logic [15:0] value,
  output logic [3:0]  valid,
  output logic [3:0]  dp,
  output logic        frame_done,
  output logic        seq_err,
  output logic        stale
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] BAD   = 2'd2;

  localparam logic [HOLD_W-1:0]    HOLD_MIN = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

  logic [3:0]           r_d_q;
  logic [7:0]           r_s_q;
  logic [1:0]           r_state;
  logic [7:0]           r_acc;
  logic [HOLD_W-1:0]    r_hold;
  logic [1:0]           r_k;
  logic [3:0]           r_seen;
  logic [TIMEOUT_W-1:0] r_tmo;

  logic                 w_zero;
  logic                 w_onehot;
  logic                 w_multi;
  logic                 w_same;
  logic [1:0]           w_idx;
  logic                 w_commit;
  logic                 w_enter_bad;
  logic [3:0]           w_dec_val;
  logic                 w_dec_ok;
  logic [3:0]           w_seen_nxt;
  logic [TIMEOUT_W-1:0] w_tmo_nxt;

  assign w_zero      = (r_d_q == 4'b0000);
  assign w_onehot    = !w_zero && ((r_d_q & (r_d_q - 4'd1)) == 4'b0000);
  assign w_multi     = !w_zero && !w_onehot;
  assign w_same      = (r_d_q == (4'b0001 << r_k));
  // Leaving into multi-hot discards the capture, so commit excludes it.
  assign w_commit    = (r_state == ACCUM) && !w_same && !w_multi && (r_hold >= HOLD_MIN);
  assign w_enter_bad = w_multi && (r_state != BAD);
  assign w_seen_nxt  = r_seen | (4'b0001 << r_k);
  assign w_tmo_nxt   = w_commit ? '0 : ((r_tmo == TMO_MAX) ? r_tmo : r_tmo + 1'b1);
  assign stale       = (r_tmo == TMO_MAX);

  // One-hot strobe to slot index
  always_comb begin
    w_idx = 2'd0;
    case (r_d_q)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // Segment pattern to BCD; blank decodes to 4'hA
  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_val = 4'hE;
    case (r_acc[6:0])
      7'h3F: w_dec_val = 4'd0;
      7'h06: w_dec_val = 4'd1;
      7'h5B: w_dec_val = 4'd2;
      7'h4F: w_dec_val = 4'd3;
      7'h66: w_dec_val = 4'd4;
      7'h6D: w_dec_val = 4'd5;
      7'h7D: w_dec_val = 4'd6;
      7'h07: w_dec_val = 4'd7;
      7'h7F: w_dec_val = 4'd8;
      7'h6F: w_dec_val = 4'd9;
      7'h00: w_dec_val = 4'hA;
      default: begin
        w_dec_val = 4'hE;
        w_dec_ok  = 1'b0;
      end
    endcase
  end

  // Input register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q <= 4'b0000;
      r_s_q <= 8'h00;
    end else begin
      r_d_q <= digits;
      r_s_q <= segments;
    end
  end

  // Capture FSM: accumulate, restart on a new strobe, park on multi-hot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= 8'h00;
      r_hold  <= '0;
      r_k     <= 2'd0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= w_enter_bad;
      if ((r_state == ACCUM) && w_same) begin
        r_acc <= r_acc | r_s_q;
        if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
      end else if (w_onehot) begin
        r_state <= ACCUM;
        r_acc   <= r_s_q;
        r_hold  <= HOLD_W'(1);
        r_k     <= w_idx;
      end else if (w_zero) begin
        r_state <= IDLE;
        r_acc   <= 8'h00;
        r_hold  <= '0;
      end else begin
        r_state <= BAD;
        r_acc   <= 8'h00;
        r_hold  <= '0;
      end
    end
  end

  // Slot outputs; valid drops when the inactivity counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 16'hEEEE;
      valid <= 4'b0000;
      dp    <= 4'b0000;
    end else if (w_commit) begin
      value[{r_k, 2'b00} +: 4] <= w_dec_val;
      valid[r_k]               <= w_dec_ok;
      dp[r_k]                  <= r_acc[7];
    end else if (w_tmo_nxt == TMO_MAX) begin
      valid <= 4'b0000;
    end
  end

  // Frame tracking and inactivity counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen     <= 4'b0000;
      frame_done <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_tmo      <= w_tmo_nxt;
      frame_done <= 1'b0;
      if (w_commit) begin
        if (w_seen_nxt == 4'hF) begin
          frame_done <= 1'b1;
          r_seen     <= 4'b0000;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_segscan_decoder.sv
// Scoreboard bench for segscan_decoder: the driver pushes expected output
// snapshots tagged with the cycle they must appear; the monitor checks them.
module tb_segscan_decoder;

  localparam int TW   = 12;
  localparam int MAXT = (1 << TW) - 1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic [15:0] value;
  logic [3:0]  valid;
  logic [3:0]  dp;
  logic        frame_done;
  logic        seq_err;
  logic        stale;

  segscan_decoder #(.MIN_HOLD(4), .HOLD_W(8), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .segments(segments),
    .value(value), .valid(valid), .dp(dp),
    .frame_done(frame_done), .seq_err(seq_err), .stale(stale)
  );

  typedef struct {
    int          cyc;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  dp;
    logic        fd;
    logic        se;
    logic        st;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t_drv = 0;
  int          lc = 0;
  logic [15:0] e_value;
  logic [3:0]  e_valid;
  logic [3:0]  e_dp;
  logic [7:0]  seg3 [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drv(input logic [3:0] d, input logic [7:0] s);
    @(negedge clk);
    digits   = d;
    segments = s;
    t_drv    = cyc;
  endtask

  task automatic push(input int c, input logic fd, input logic se, input logic st);
    exp_t x;
    x.cyc = c; x.value = e_value; x.valid = e_valid; x.dp = e_dp;
    x.fd = fd; x.se = se; x.st = st;
    q.push_back(x);
  endtask

  // Monitor: compare scheduled snapshots, otherwise require no pulses
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missed_snapshot cyc=%0d expected_at=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      total++;
      if (value !== e.value || valid !== e.valid || dp !== e.dp ||
          frame_done !== e.fd || seq_err !== e.se || stale !== e.st) begin
        bad++;
        $display("FAIL snapshot cyc=%0d got value=%h valid=%b dp=%b fd=%b se=%b st=%b want value=%h valid=%b dp=%b fd=%b se=%b st=%b",
                 cyc, value, valid, dp, frame_done, seq_err, stale,
                 e.value, e.valid, e.dp, e.fd, e.se, e.st);
      end
    end else begin
      total++;
      if (frame_done !== 1'b0 || seq_err !== 1'b0) begin
        bad++;
        $display("FAIL spurious_pulse cyc=%0d got fd=%b se=%b want 0 0", cyc, frame_done, seq_err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    seg3[0] = 8'h01; seg3[1] = 8'h02; seg3[2] = 8'h04; seg3[3] = 8'h08;
    seg3[4] = 8'h40; seg3[5] = 8'h80; seg3[6] = 8'h00; seg3[7] = 8'h00;
    e_value = 16'hEEEE; e_valid = 4'b0000; e_dp = 4'b0000;
    rst_n = 1'b0; digits = 4'b0000; segments = 8'h00;

    // Reset state, during and after reset
    @(negedge clk);
    push(cyc + 1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) drv(4'b0000, 8'h00);
    push(cyc + 1, 1'b0, 1'b0, 1'b0);

    // Digit 1 shows "1" for 6 cycles
    repeat (6) drv(4'b0010, 8'h06);
    drv(4'b0000, 8'h00);
    e_value[7:4] = 4'd1; e_valid[1] = 1'b1;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0000, 8'h00);

    // Digit 0 builds "3." one segment at a time
    for (int i = 0; i < 8; i++) drv(4'b0001, seg3[i]);
    drv(4'b0000, 8'h00);
    e_value[3:0] = 4'd3; e_valid[0] = 1'b1; e_dp[0] = 1'b1;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0000, 8'h00);

    // Full frame 3,3,6,3 with direct digit-to-digit handoff
    repeat (4) drv(4'b0001, 8'h4F);
    drv(4'b0010, 8'h4F);
    e_dp[0] = 1'b0;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0010, 8'h4F);
    drv(4'b0100, 8'h7D);
    e_value[7:4] = 4'd3;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0100, 8'h7D);
    drv(4'b1000, 8'h4F);
    e_value[11:8] = 4'd6; e_valid[2] = 1'b1;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b1000, 8'h4F);
    drv(4'b0000, 8'h00);
    e_value[15:12] = 4'd3; e_valid[3] = 1'b1;
    push(t_drv + 2, 1'b1, 1'b0, 1'b0);
    repeat (3) drv(4'b0000, 8'h00);

    // Glitch: 2-cycle strobe is discarded
    repeat (2) drv(4'b1000, 8'h7F);
    drv(4'b0000, 8'h00);
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0000, 8'h00);

    // Multi-hot from idle, then one-hot straight to multi-hot
    drv(4'b0011, 8'h00);
    push(t_drv + 2, 1'b0, 1'b1, 1'b0);
    repeat (2) drv(4'b0011, 8'h00);
    drv(4'b0000, 8'h00);
    repeat (3) drv(4'b0000, 8'h00);
    repeat (5) drv(4'b0010, 8'h5B);
    drv(4'b0110, 8'h5B);
    push(t_drv + 2, 1'b0, 1'b1, 1'b0);
    repeat (2) drv(4'b0111, 8'h5B);
    drv(4'b0000, 8'h00);
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(4'b0000, 8'h00);

    // Unrecognised pattern on digit 2
    repeat (5) drv(4'b0100, 8'h01);
    drv(4'b0000, 8'h00);
    e_value[11:8] = 4'hE; e_valid[2] = 1'b0;
    lc = t_drv + 2;
    push(lc, 1'b0, 1'b0, 1'b0);

    // Inactivity timeout
    push(lc + MAXT - 1, 1'b0, 1'b0, 1'b0);
    e_valid = 4'b0000;
    push(lc + MAXT, 1'b0, 1'b0, 1'b1);
    while (cyc < lc + MAXT + 3) drv(4'b0000, 8'h00);

    // Next commit clears stale
    repeat (4) drv(4'b0001, 8'h3F);
    drv(4'b0000, 8'h00);
    e_value[3:0] = 4'd0; e_valid[0] = 1'b1;
    push(t_drv + 2, 1'b0, 1'b0, 1'b0);
    repeat (5) drv(4'b0000, 8'h00);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_snapshots got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segscan_decoder.md
Name: segscan_decoder

Overview:
- Receive-side monitor for the multiplexed 4-digit 7-segment scan bus: one-hot `digits`, active-high `segments` (bit7 = DP).
- For each digit it ORs all segments lit while that digit strobe is held, then decodes the pattern back to a BCD value when the strobe ends.
- Used as an on-chip loopback checker for display drivers and as the bench's golden reader of what the display actually shows.

Parameters:
- MIN_HOLD, 4: minimum consecutive cycles a single digit strobe must be held for its capture to be committed; shorter strobes are glitches and are discarded.
- HOLD_W, 8: width of the strobe-hold counter, which saturates at all-ones.
- TIMEOUT_W, 16: width of the inactivity counter; `stale` asserts when it saturates.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- digits, input, 4: digit strobes, active high, expected one-hot or zero.
- segments, input, 8: segment lines {DP,G,F,E,D,C,B,A}, active high.
- value, output, 16: decoded digit i in value[4i+3:4i].
- valid, output, 4: valid[i] = 1 when slot i holds a recognised pattern (0-9 or blank).
- dp, output, 4: decimal point captured for each slot.
- frame_done, output, 1: one-cycle pulse when all 4 slots have been committed since the last pulse.
- seq_err, output, 1: one-cycle pulse on a multi-hot `digits` sample.
- stale, output, 1: no committed capture for 2^TIMEOUT_W-1 cycles.

Behaviour:
- Input stage: `digits` and `segments` are registered once (d_q, s_q). All decisions use the registered values.
- Reset (async, rst_n=0): value=16'hEEEE, valid=0, dp=0, frame_done=0, seq_err=0, stale=0. Internal state: IDLE, acc=0, hold=0, seen mask=0, timeout counter=0.
- FSM states:
  - IDLE: d_q==0.
  - ACCUM: d_q one-hot with index k.
  - BAD: d_q multi-hot.
- IDLE → ACCUM on a one-hot d_q: acc = s_q, hold = 1, k latched.
- ACCUM, d_q unchanged: acc |= s_q; hold increments, saturating at all-ones.
- ACCUM, d_q changes to anything else: commit slot k if hold ≥ MIN_HOLD, otherwise discard silently. Then go to the state that matches the new d_q, starting a fresh acc/hold if it is one-hot.
- Commit decode on acc[6:0]:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 00→4'hA (blank); valid[k]=1.
  - Any other pattern → 4'hE, valid[k]=0.
  - dp[k] = acc[7].
- Commit latency: outputs update on the 2nd rising edge after the edge where raw `digits` changed (one cycle input register, one cycle commit).
- BAD: entering BAD pulses seq_err for exactly one cycle. Any capture in progress is discarded without commit. Stay in BAD until d_q is zero or one-hot; a multi-hot to multi-hot change does not re-pulse.
- Frame tracking:
  - Each commit sets seen[k], including invalid patterns.
  - When seen becomes 4'hF, pulse frame_done on the same cycle as the commit and clear seen.
  - Recommitting an already-seen slot does not reset the mask.
- Timeout: the counter clears on every commit and otherwise increments, saturating. stale = (counter == all-ones). On reaching saturation, valid clears to 0; value and dp hold their last contents. The next commit clears stale.
- Simultaneous events: a commit and entering BAD in the same cycle cannot occur, because the commit only happens on leaving ACCUM; if d_q goes from one-hot straight to multi-hot, the capture is discarded and seq_err pulses.
- Reset mid-capture: all state clears immediately. A strobe still held when rst_n releases is captured from the first registered sample, so hold counts from that point.

Test Plan:
- Reset, then digits=0 for 10 cycles → value=16'hEEEE, valid=0, dp=0, no pulses.
- digits=4'b0010 for 6 cycles with segments=8'h06, then digits=0 → two edges after release: value[7:4]=1, valid[1]=1, dp[1]=0.
- Segment-by-segment "3": digits=4'b0001 for 8 cycles, segments stepping one bit per cycle through A,B,C,D,G plus DP → value[3:0]=3, valid[0]=1, dp[0]=1.
- Full frame, digits 0..3 showing 3,3,6,3 (MIN_HOLD cycles each) → one frame_done pulse on the final commit; value=16'h3633, valid=4'hF.
- Glitch: digits=4'b1000 for 2 cycles with segments=8'h7F → no commit; value[15:12] unchanged, no frame_done.
- Error paths:
  - digits=4'b0011 → seq_err high for exactly 1 cycle, no commit.
  - Pattern 8'h01 held 5 cycles on digit 2 → value[11:8]=E, valid[2]=0.
  - No activity for 2^TIMEOUT_W cycles → stale=1, valid=0.
